// File: rtl/engine_filter_cond_sequencer.sv
// Run sequencer for one filter-condition kernel: clears it, issues packets under credit
// control, tracks in-flight results and buffers them in a first-word fall-through FIFO.
module engine_filter_cond_sequencer #(
  parameter int unsigned NUM_FIELDS     = 4,
  parameter int unsigned FIELD_W        = 32,
  parameter int unsigned KERNEL_LATENCY = 2,
  parameter int unsigned OUT_FIFO_DEPTH = 8,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          start_in,
  input  logic [CNT_W-1:0]              cfg_count_in,
  input  logic                          cfg_drop_false_in,
  output logic                          busy_out,
  output logic                          done_out,
  input  logic                          in_valid,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
  output logic                          in_ready,
  output logic                          kern_clear_out,
  output logic                          kern_cfg_valid_out,
  output logic                          kern_data_valid_out,
  output logic [NUM_FIELDS*FIELD_W-1:0] kern_data_out,
  input  logic                          kern_result_flag_in,
  input  logic [NUM_FIELDS*FIELD_W-1:0] kern_result_data_in,
  output logic                          out_valid,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
  output logic                          out_flag,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              pass_count_out,
  output logic [CNT_W-1:0]              drop_count_out
);

  localparam int unsigned DW = NUM_FIELDS * FIELD_W;
  localparam int unsigned EW = DW + 1;
  localparam int unsigned AW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int unsigned OW = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int unsigned LW = KERNEL_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drop_en_q, drop_en_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [LW-1:0]      tag_q, tag_d;
  logic [OW-1:0]      inflight_q, inflight_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]      mem_q [OUT_FIFO_DEPTH];
  logic [EW-1:0]      mem_d [OUT_FIFO_DEPTH];
  logic [DW-1:0]      kern_data_q, kern_data_d;
  logic               kern_dv_q, kern_dv_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               kclear_q, kclear_d;
  logic               kcfg_q, kcfg_d;

  logic issue, exit_tag, drop_it, push, pop, fifo_full;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_FIFO_DEPTH - 1)) ? '0 : AW'(p + AW'(1));
  endfunction

  assign issue     = in_valid && in_ready_q;
  assign exit_tag  = tag_q[LW-1];
  assign drop_it   = exit_tag && drop_en_q && !kern_result_flag_in;
  assign push      = exit_tag && !drop_it;
  assign pop       = out_valid_q && out_ready;
  assign fifo_full = (occ_q == OW'(OUT_FIFO_DEPTH));

  // State register
  always_ff @(posedge ap_clk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath next values: issue pipe, FIFO, counters, run configuration
  always_comb begin
    count_d     = count_q;
    drop_en_d   = drop_en_q;
    issued_d    = issued_q;
    pass_cnt_d  = pass_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    tag_d       = LW'({tag_q, issue});
    inflight_d  = OW'(inflight_q + OW'(issue) - OW'(exit_tag));
    occ_d       = OW'(occ_q + OW'(push) - OW'(pop));
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    mem_d       = mem_q;
    kern_data_d = issue ? in_data : kern_data_q;
    kern_dv_d   = |tag_d;
    out_valid_d = (occ_d != '0);
    if (push) mem_d[wr_ptr_q] = {kern_result_flag_in, kern_result_data_in};
    if (issue) issued_d = CNT_W'(issued_q + CNT_W'(1));
    if (push && (pass_cnt_q != '1)) pass_cnt_d = CNT_W'(pass_cnt_q + CNT_W'(1));
    if (drop_it && (drop_cnt_q != '1)) drop_cnt_d = CNT_W'(drop_cnt_q + CNT_W'(1));
    if ((state_q == S_IDLE) && start_in) begin
      count_d    = cfg_count_in;
      drop_en_d  = cfg_drop_false_in;
      issued_d   = '0;
      pass_cnt_d = '0;
      drop_cnt_d = '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_CLEAR;
      S_CLEAR: state_d = (count_q == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (issued_d == count_q) state_d = S_DRAIN;
      S_DRAIN: if ((occ_d == '0) && (inflight_d == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; credit counts pushes/pops of this cycle via the _d values
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    kclear_d   = (state_d == S_CLEAR);
    kcfg_d     = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
    in_ready_d = (state_d == S_RUN) && (issued_d < count_d) &&
                 ((OW + 1)'(occ_d) + (OW + 1)'(inflight_d) < (OW + 1)'(OUT_FIFO_DEPTH));
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      count_q     <= '0;
      drop_en_q   <= 1'b0;
      issued_q    <= '0;
      pass_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < int'(OUT_FIFO_DEPTH); i++) mem_q[i] <= '0;
      kern_data_q <= '0;
      kern_dv_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      kclear_q    <= 1'b1;
      kcfg_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      drop_en_q   <= drop_en_d;
      issued_q    <= issued_d;
      pass_cnt_q  <= pass_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      kern_data_q <= kern_data_d;
      kern_dv_q   <= kern_dv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      kclear_q    <= kclear_d;
      kcfg_q      <= kcfg_d;
    end
  end

  // Credit rule must make a push into a full, non-popping FIFO impossible
  assert property (@(posedge ap_clk) disable iff (areset) !(push && fifo_full && !pop))
    else $error("result FIFO overflow");

  assign busy_out            = busy_q;
  assign done_out            = done_q;
  assign in_ready            = in_ready_q;
  assign kern_clear_out      = kclear_q;
  assign kern_cfg_valid_out  = kcfg_q;
  assign kern_data_valid_out = kern_dv_q;
  assign kern_data_out       = kern_data_q;
  assign out_valid           = out_valid_q;
  assign out_data            = mem_q[rd_ptr_q][DW-1:0];
  assign out_flag            = mem_q[rd_ptr_q][DW];
  assign pass_count_out      = pass_cnt_q;
  assign drop_count_out      = drop_cnt_q;

endmodule

// File: tb/tb_engine_filter_cond_sequencer.sv
// Scoreboard bench for engine_filter_cond_sequencer with a two-cycle kernel model
// (flag = packet bit 0, result data = packet XOR a fixed mask).
module tb_engine_filter_cond_sequencer;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 32;
  localparam logic [DW-1:0] MASK = 128'h5A5A_0000_FFFF_0000_0F0F_F0F0_1234_5678;

  logic          ap_clk = 1'b0;
  logic          areset;
  logic          start_in;
  logic [CW-1:0] cfg_count_in;
  logic          cfg_drop_false_in;
  logic          busy_out, done_out;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          kern_clear_out, kern_cfg_valid_out, kern_data_valid_out;
  logic [DW-1:0] kern_data_out;
  logic          kern_result_flag_in;
  logic [DW-1:0] kern_result_data_in;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_flag;
  logic          out_ready;
  logic [CW-1:0] pass_count_out, drop_count_out;

  always #5 ap_clk = ~ap_clk;

  engine_filter_cond_sequencer dut (
    .ap_clk(ap_clk), .areset(areset), .start_in(start_in),
    .cfg_count_in(cfg_count_in), .cfg_drop_false_in(cfg_drop_false_in),
    .busy_out(busy_out), .done_out(done_out),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .kern_clear_out(kern_clear_out), .kern_cfg_valid_out(kern_cfg_valid_out),
    .kern_data_valid_out(kern_data_valid_out), .kern_data_out(kern_data_out),
    .kern_result_flag_in(kern_result_flag_in), .kern_result_data_in(kern_result_data_in),
    .out_valid(out_valid), .out_data(out_data), .out_flag(out_flag), .out_ready(out_ready),
    .pass_count_out(pass_count_out), .drop_count_out(drop_count_out)
  );

  // Kernel model: result appears two cycles after the issue edge
  logic [DW-1:0] kres_q = '0;
  always @(posedge ap_clk) kres_q <= kern_data_out;
  assign kern_result_data_in = kres_q ^ MASK;
  assign kern_result_flag_in = kres_q[0];

  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, busy_cnt = 0, kdv_cnt = 0;
  int last_pop_cyc = -1, done_cyc = -1, accepted = 0;
  logic [DW:0]   sb[$];
  logic [DW-1:0] pkt[32];

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Output monitor: pop expected entry on every accepted result
  always @(negedge ap_clk) begin
    if (!areset) begin
      if (done_out) begin done_cnt++; done_cyc = cyc; end
      if (busy_out) busy_cnt++;
      if (kern_data_valid_out) kdv_cnt++;
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected: got flag %0b data %h, nothing expected", out_flag, out_data);
        end else begin
          logic [DW:0] e;
          e = sb.pop_front();
          if ({out_flag, out_data} !== e) begin
            fails++;
            $display("FAIL out_result: got %0b/%h expected %0b/%h", out_flag, out_data, e[DW], e[DW-1:0]);
          end
        end
        last_pop_cyc = cyc;
      end
    end
  end

  function automatic logic [DW-1:0] mk(input int i, input bit f);
    return {32'hC0DE_0000 + 32'(i), 32'h1000_0000 + 32'(i * 3), 32'hBEEF_0000 ^ 32'(i),
            31'(i * 5 + 1), f};
  endfunction

  task automatic drive(input int n, input bit drop, input int poke_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pkt[i];
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
        @(negedge ap_clk);
        if (in_ready) ok = 1'b1;
      end
      if (!ok) begin
        chk("in_ready_timeout", 64'(i), 64'(n));
        break;
      end
      if (!(drop && !pkt[i][0])) sb.push_back({pkt[i][0], pkt[i] ^ MASK});
      accepted++;
      @(posedge ap_clk); #1;
      start_in = (i + 1 == poke_at);
      if (i + 1 == poke_at) cfg_count_in = 32'd2;
    end
    in_valid = 1'b0;
    start_in = 1'b0;
  endtask

  task automatic run(input string nm, input int cnt, input bit drop, input int n,
                     input int poke_at, input int hold, input int exp_pass, input int exp_drop);
    bit got_done;
    done_cnt = 0; busy_cnt = 0; kdv_cnt = 0; accepted = 0; last_pop_cyc = -1;
    out_ready = (hold == 0);
    cfg_count_in = 32'(cnt); cfg_drop_false_in = drop; start_in = 1'b1;
    @(posedge ap_clk); #1;
    start_in = 1'b0; cfg_count_in = 32'd99; cfg_drop_false_in = ~drop;
    fork
      drive(n, drop, poke_at);
      if (hold > 0) begin
        repeat (hold) @(posedge ap_clk);
        @(negedge ap_clk);
        chk({nm, "_accepted_at_hold"}, 64'(accepted), 64'd8);
        chk({nm, "_in_ready_at_hold"}, 64'(in_ready), 64'd0);
        @(posedge ap_clk); #1;
        out_ready = 1'b1;
      end
    join
    got_done = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge ap_clk);
      if (done_out) got_done = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(got_done), 64'd1);
    @(negedge ap_clk);
    chk({nm, "_busy_after_done"}, 64'(busy_out), 64'd0);
    repeat (5) @(negedge ap_clk);
    chk({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, "_pass"}, 64'(pass_count_out), 64'(exp_pass));
    chk({nm, "_drop"}, 64'(drop_count_out), 64'(exp_drop));
    chk({nm, "_sb_left"}, 64'(sb.size()), 64'd0);
    if (exp_pass > 0) chk({nm, "_done_after_pop"}, 64'(done_cyc - last_pop_cyc), 64'd1);
    if (cnt == 0) begin
      chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'd3);
      chk({nm, "_no_issue"}, 64'(kdv_cnt), 64'd0);
    end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pkt[i] = mk(i, (i % 3) != 1);
    pkt[0] = mk(0, 1'b1); pkt[1] = mk(1, 1'b0); pkt[2] = mk(2, 1'b1); pkt[3] = mk(3, 1'b1);
    areset = 1'b1; start_in = 1'b0; cfg_count_in = '0; cfg_drop_false_in = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_kclear", 64'(kern_clear_out), 64'd1);
    chk("rst_kcfg", 64'(kern_cfg_valid_out), 64'd0);
    chk("rst_kdv", 64'(kern_data_valid_out), 64'd0);
    chk("rst_pass", 64'(pass_count_out), 64'd0);
    @(posedge ap_clk); #1;
    areset = 1'b0;
    repeat (2) @(posedge ap_clk); #1;

    run("t1_nodrop", 4, 1'b0, 4, -1, 0, 4, 0);
    run("t2_drop", 4, 1'b1, 4, -1, 0, 3, 1);
    run("t3_backpressure", 20, 1'b0, 20, -1, 30, 20, 0);
    run("t4_zero", 0, 1'b0, 0, -1, 0, 0, 0);
    run("t5_restart_ignored", 6, 1'b0, 6, 2, 0, 6, 0);

    // Reset in the middle of a run with two packets in flight
    done_cnt = 0; out_ready = 1'b1;
    cfg_count_in = 32'd5; cfg_drop_false_in = 1'b0; start_in = 1'b1;
    @(posedge ap_clk); #1;
    start_in = 1'b0;
    drive(2, 1'b0, -1);
    areset = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("t6_busy", 64'(busy_out), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk("t6_kdv", 64'(kern_data_valid_out), 64'd0);
    chk("t6_kdata", 64'(kern_data_out[63:0]), 64'd0);
    chk("t6_pass", 64'(pass_count_out), 64'd0);
    chk("t6_kclear", 64'(kern_clear_out), 64'd1);
    sb.delete();
    @(posedge ap_clk); #1;
    areset = 1'b0;
    repeat (6) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    @(posedge ap_clk); #1;
    run("t6_rerun", 4, 1'b1, 4, -1, 0, 3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
    $fatal(1);
  end

endmodule
